muldiv_hilo: RTL and testbench
==============================

Name:
muldiv_hilo

Overview:
- Sequential multiply/divide unit that owns the architectural HI/LO register pair for the MIPS datapath.
- Accepts operand pairs over the same sr/tg operand interface that feeds the combinational ALU, iterates radix-2 over 32 cycles, and writes the 64-bit product or the quotient/remainder into HI/LO.
- The decode/pipeline control issues start and stalls on busy; mfhi/mflo read hi/lo directly; mthi/mtlo write through this block.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when busy=0.
- op  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start.
- sr  input  WIDTH  multiplicand / dividend; sampled with start.
- tg  input  WIDTH  multiplier / divisor; sampled with start.
- mthi  input  1  write wdata to HI; ignored while busy=1.
- mtlo  input  1  write wdata to LO; ignored while busy=1.
- wdata  input  WIDTH  data for mthi/mtlo.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
- div_by_zero  output  1  pulses with done when a div/divu had tg=0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0. Reset mid-operation aborts immediately; HI/LO return to 0.
- States:
  - IDLE: start=1 at edge E0 latches op, sign flags, and |sr|, |tg| (magnitudes for signed ops, raw values for unsigned ops). Moves to CALC; busy=1 after E0.
  - CALC: one shift-add (mult) or restoring shift-subtract (div) step per clock, counter 0..WIDTH-1. After the WIDTH-th step (edge E32), moves to FIX.
  - FIX (edge E33): applies sign correction, writes HI/LO, sets done=1 for one cycle, busy=0, returns to IDLE.
- Latency: done is visible 33 clocks after the start edge. A new start is accepted in the done cycle.
- Multiply result: HI:LO = full 64-bit product. For mult, the 64-bit magnitude is negated when the operand signs differ.
- Divide result: LO = quotient, HI = remainder.
  - div: quotient is negated when signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps; no trap).
- Divide by zero: skips CALC and goes straight to FIX. Writes HI=sr, LO=0xFFFFFFFF; div_by_zero=1 with done; latency is 2 clocks.
- start while busy=1: ignored; operands are not re-sampled.
- mthi/mtlo: honoured only when busy=0, in that cycle. If start is accepted in the same cycle, the write lands and is later overwritten at FIX. mthi and mtlo may both be asserted together.
- hi/lo are stable during CALC; intermediate state is held in internal registers only.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: for mult/multu, CALC exits to FIX as soon as the remaining unshifted multiplier magnitude is zero. Latency = 2 + index of the highest set bit of |tg|, plus 1. tg=0 gives latency 2. Divide latency is unchanged.
- Undefined: fixed 33-cycle latency for every non-zero-divisor operation.

Test Plan:
- mult, sr=0xFFFFFFFD, tg=7 -> done 33 clocks after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy=1 for exactly 33 cycles.
- multu, sr=tg=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. With MULDIV_EARLY_OUT_EN and tg=1 -> done after 3 clocks, hi=0, lo=sr.
- div, sr=0xFFFFFFF9 (-7), tg=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu, sr=100, tg=7 -> lo=14, hi=2.
- divu, sr=0x1234, tg=0 -> done and div_by_zero together 2 clocks after start; hi=0x1234, lo=0xFFFFFFFF.
- During busy: start with new operands and mthi wdata=0xAAAA5555 -> both ignored; result matches the original operands. After done: mthi then mtlo -> hi and lo read back the written values.
- rst_n=0 at cycle 10 of a mult -> busy=0, hi=lo=0 immediately (asynchronously); no done pulse; the next start completes normally.

Source files
------------

// File: rtl/muldiv_hilo.sv
// Sequential radix-2 multiply/divide unit owning the HI/LO register pair.
// Optional MULDIV_EARLY_OUT_EN: mult/multu leave CALC once the remaining multiplier is zero.
module muldiv_hilo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] sr,
    input  logic [WIDTH-1:0] tg,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    // r_p: product accumulator (mult) or partial remainder (div)
    logic [PW-1:0]    r_p;
    // r_mc: shifting multiplicand (mult) or divisor in the low half (div)
    logic [PW-1:0]    r_mc;
    // r_q: multiplier shifting right (mult) or dividend/quotient shifting left (div)
    logic [WIDTH-1:0] r_q;

    logic             w_signed;
    logic             w_sr_neg;
    logic             w_tg_neg;
    logic             w_tg_zero;
    logic [WIDTH-1:0] w_sr_mag;
    logic [WIDTH-1:0] w_tg_mag;
    logic [PW-1:0]    w_p_mul;
    logic [WIDTH:0]   w_shift;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_rem;
    logic [PW-1:0]    w_prod;
    logic             w_mul_exit;

    // Operand magnitudes; unsigned ops (op[0]=1) pass through untouched
    assign w_signed  = ~op[0];
    assign w_sr_neg  = w_signed & sr[WIDTH-1];
    assign w_tg_neg  = w_signed & tg[WIDTH-1];
    assign w_tg_zero = (tg == '0);
    assign w_sr_mag  = w_sr_neg ? -sr : sr;
    assign w_tg_mag  = w_tg_neg ? -tg : tg;

    assign w_p_mul = r_p + (r_q[0] ? r_mc : '0);

    // Restoring step; a fitting difference is always below the divisor, so WIDTH bits suffice
    assign w_shift   = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_fits    = (w_shift >= {1'b0, r_mc[WIDTH-1:0]});
    assign w_diff    = w_shift[WIDTH-1:0] - r_mc[WIDTH-1:0];
    assign w_rem_nxt = w_fits ? w_diff : w_shift[WIDTH-1:0];

    assign w_rem  = r_p[WIDTH-1:0];
    assign w_prod = r_neg_q ? -r_p : r_p;

`ifdef MULDIV_EARLY_OUT_EN
    assign w_mul_exit = ~r_div & (r_q == '0);
`else
    assign w_mul_exit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_p     <= '0;
            r_mc    <= '0;
            r_q     <= '0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mthi) r_hi <= wdata;
                    if (mtlo) r_lo <= wdata;
                    if (start) begin
                        r_state <= S_CALC;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_div   <= op[1];
                        r_neg_q <= w_sr_neg ^ w_tg_neg;
                        r_neg_r <= w_sr_neg;
                        r_dz    <= op[1] & w_tg_zero;
                        r_p     <= '0;
                        r_mc    <= PW'(op[1] ? w_tg_mag : w_sr_mag);
                        // A zero divisor keeps the raw dividend for HI
                        r_q     <= op[1] ? (w_tg_zero ? sr : w_sr_mag) : w_tg_mag;
                    end
                end
                S_CALC: begin
                    if (r_dz || w_mul_exit) begin
                        r_state <= S_FIX;
                    end else begin
                        if (r_div) begin
                            r_p <= PW'(w_rem_nxt);
                            r_q <= {r_q[WIDTH-2:0], w_fits};
                        end else begin
                            r_p  <= w_p_mul;
                            r_mc <= r_mc << 1;
                            r_q  <= r_q >> 1;
                        end
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_dz) begin
                        r_hi  <= r_q;
                        r_lo  <= '1;
                        r_dbz <= 1'b1;
                    end else if (r_div) begin
                        r_lo <= r_neg_q ? -r_q : r_q;
                        r_hi <= r_neg_r ? -w_rem : w_rem;
                    end else begin
                        r_hi <= w_prod[PW-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: random and directed operations against a plain-arithmetic model.
module tb_muldiv_hilo;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] sr = '0;
    logic [W-1:0] tg = '0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
        int           when_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

    muldiv_hilo #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .sr         (sr),
        .tg         (tg),
        .mthi       (mthi),
        .mtlo       (mtlo),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: MIPS mult/multu/div/divu semantics with wide integer arithmetic
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   r;
        longint sa;
        longint sb_v;
        longint q;
        longint rm;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        r.dbz = 1'b0;
        r.lat = 33;
        r.when_cyc = 0;
        r.hi = '0;
        r.lo = '0;
        case (o)
            2'b00: begin
                p = 64'(sa * sb_v);
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            default: begin
                if (b == '0) begin
                    r.hi  = a;
                    r.lo  = '1;
                    r.dbz = 1'b1;
                    r.lat = 2;
                end else if (o == 2'b10) begin
                    q  = sa / sb_v;
                    rm = sa % sb_v;
                    r.lo = W'(q);
                    r.hi = W'(rm);
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 64'(done), 64'd0);
            end else begin
                m_e = sb.pop_front();
                chk("hi", 64'(hi), 64'(m_e.hi));
                chk("lo", 64'(lo), 64'(m_e.lo));
                chk("div_by_zero", 64'(div_by_zero), 64'(m_e.dbz));
                chk("done_cycle", 64'(cyc), 64'(m_e.when_cyc));
            end
        end
    end

    // Called just after a falling edge; returns at the falling edge that shows done
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke);
        exp_t e;
        int   bc;
        bit   seen;
        e = model(o, a, b);
        e.when_cyc = cyc + 1 + e.lat;
        sb.push_back(e);
        op = o;
        sr = a;
        tg = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bc++;
            if (poke && k == 4) begin
                start = 1'b1;
                op    = 2'b11;
                sr    = $urandom;
                tg    = $urandom | 32'd1;
                mthi  = 1'b1;
                wdata = 32'hAAAA5555;
            end else if (poke && k == 5) begin
                start = 1'b0;
                mthi  = 1'b0;
            end
            @(negedge clk);
        end
        chk("completed", 64'(seen), 64'd1);
        chk("busy_cycles", 64'(bc), 64'(e.lat));
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           sel;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0);
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        issue(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
        issue(2'b11, 32'd100, 32'd7, 1'b0);
        issue(2'b11, 32'h00001234, 32'd0, 1'b0);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        issue(2'b10, 32'hFFFFFFF9, 32'd0, 1'b0);
        issue(2'b00, 32'h80000000, 32'h80000000, 1'b0);
        issue(2'b10, 32'd7, 32'hFFFFFFFE, 1'b0);
        issue(2'b00, 32'h12345678, 32'h9ABCDEF0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = '0;
            if (sel == 1) rb = W'($urandom_range(1, 3));
            if (sel == 2) ra = 32'h80000000;
            if (sel == 3) rb = 32'hFFFFFFFF;
            issue(ro, ra, rb, 1'b0);
        end

        mthi = 1'b1;
        wdata = 32'h13579BDF;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_hi", 64'(hi), 64'h13579BDF);
        mtlo = 1'b1;
        wdata = 32'h2468ACE0;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h2468ACE0);
        chk("mtlo_hi_kept", 64'(hi), 64'h13579BDF);
        mthi = 1'b1;
        mtlo = 1'b1;
        wdata = 32'hCAFEF00D;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        chk("both_hi", 64'(hi), 64'hCAFEF00D);
        chk("both_lo", 64'(lo), 64'hCAFEF00D);

        // Abort a multiply part-way through with an asynchronous reset
        op = 2'b00;
        sr = 32'h00012345;
        tg = 32'h00054321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_abort_busy", 64'(busy), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", 64'(done), 64'd0);
        issue(2'b01, 32'h00012345, 32'h00054321, 1'b0);
        issue(2'b10, 32'h80000000, 32'd3, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
